// File: rtl/i2c_apb_regif.sv
// APB3 register front-end with TX/RX byte FIFOs for core_i2c.
// Optional interrupt block enabled by defining I2C_REGIF_IRQ_EN.

module i2c_apb_regif_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               wdata,
  output logic [7:0]               head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   lvl
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          push_ok, pop_ok;

  // full/empty come from the registered level, so same-cycle ops see the old state
  assign empty   = (lvl == '0);
  assign full    = (lvl == (AW+1)'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rp];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp  <= '0;
      rp  <= '0;
      lvl <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      if (push_ok && !pop_ok)      lvl <= lvl + 1'b1;
      else if (pop_ok && !push_ok) lvl <= lvl - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok && !flush) begin
      mem[wp] <= wdata;
    end
  end
endmodule

module i2c_apb_regif #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        i_ready,
  input  logic [7:0]  status,
  output logic [7:0]  tx_apb_addr,
  output logic [7:0]  tx_apb_data_cnt,
  output logic [15:0] tx_ctrl,
  output logic        i_txff_empty,
  input  logic        i_txff_rd,
  output logic [7:0]  data_out_ff,
  output logic        i_rxff_full,
  input  logic        i_rxff_wr,
  input  logic [7:0]  data_in_ff,
  output logic        irq
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] A_CTRL = 8'h00, A_ADDR = 8'h04, A_CNT  = 8'h08, A_TXD = 8'h0C,
                         A_RXD  = 8'h10, A_STAT = 8'h14, A_CMD  = 8'h18,
                         A_IMSK = 8'h1C, A_ISTAT = 8'h20;

  logic          acc, wr, rd, mapped;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic [AW:0]   tx_lvl, rx_lvl;
  logic [7:0]    rx_head;
  logic          tx_flush, rx_flush;
  logic          tx_ovf, rx_udf, rx_ovf;
  logic          tx_push_err, rx_pop_err;
  logic [31:0]   stat_word;
  logic          unused_pwdata;

  assign acc    = psel & penable;
  assign wr     = acc & pwrite;
  assign rd     = acc & ~pwrite;
  assign pready = 1'b1;
  assign unused_pwdata = ^pwdata[31:16];

  assign tx_flush    = wr && (paddr == A_CMD) && pwdata[1];
  assign rx_flush    = wr && (paddr == A_CMD) && pwdata[2];
  assign tx_push_err = wr && (paddr == A_TXD) && tx_full;
  assign rx_pop_err  = rd && (paddr == A_RXD) && rx_empty;

  i2c_apb_regif_fifo #(.DEPTH(DEPTH)) u_txff (
    .clk(clk), .rst(rst),
    .push(wr && (paddr == A_TXD)), .pop(i_txff_rd), .flush(tx_flush),
    .wdata(pwdata[7:0]), .head(data_out_ff),
    .empty(tx_empty), .full(tx_full), .lvl(tx_lvl)
  );

  i2c_apb_regif_fifo #(.DEPTH(DEPTH)) u_rxff (
    .clk(clk), .rst(rst),
    .push(i_rxff_wr), .pop(rd && (paddr == A_RXD)), .flush(rx_flush),
    .wdata(data_in_ff), .head(rx_head),
    .empty(rx_empty), .full(rx_full), .lvl(rx_lvl)
  );

  assign i_txff_empty = tx_empty;
  assign i_rxff_full  = rx_full;
  assign stat_word = {8'(rx_lvl), 8'(tx_lvl), 1'b0, rx_ovf, rx_udf, tx_ovf,
                      rx_full, rx_empty, tx_full, tx_empty, status};

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ctrl         <= '0;
      tx_apb_addr     <= '0;
      tx_apb_data_cnt <= '0;
      i_ready         <= 1'b0;
    end else begin
      i_ready <= wr && (paddr == A_CMD) && pwdata[0];
      if (wr && paddr == A_CTRL) tx_ctrl         <= pwdata[15:0];
      if (wr && paddr == A_ADDR) tx_apb_addr     <= pwdata[7:0];
      if (wr && paddr == A_CNT)  tx_apb_data_cnt <= pwdata[7:0];
    end
  end

  // A new error event in the same cycle as its W1C keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (wr && paddr == A_STAT) begin
        tx_ovf <= tx_ovf & ~pwdata[12];
        rx_udf <= rx_udf & ~pwdata[13];
        rx_ovf <= rx_ovf & ~pwdata[14];
      end
      if (tx_push_err)           tx_ovf <= 1'b1;
      if (rx_pop_err)            rx_udf <= 1'b1;
      if (i_rxff_wr && rx_full)  rx_ovf <= 1'b1;
    end
  end

`ifdef I2C_REGIF_IRQ_EN
  logic [3:0] irq_mask, irq_stat, irq_cond;
  logic       done_q;

  assign irq_cond = {tx_ovf | rx_udf | rx_ovf, ~rx_empty, tx_empty, status[3] & ~done_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_mask <= '0;
      irq_stat <= '0;
      done_q   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      done_q <= status[3];
      if (wr && paddr == A_IMSK) irq_mask <= pwdata[3:0];
      irq_stat <= (irq_stat & ~((wr && paddr == A_ISTAT) ? pwdata[3:0] : 4'h0)) | irq_cond;
      irq      <= |(irq_stat & irq_mask);
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    mapped = 1'b0;
    case (paddr)
      A_CTRL, A_ADDR, A_CNT, A_TXD, A_RXD, A_STAT, A_CMD: mapped = 1'b1;
`ifdef I2C_REGIF_IRQ_EN
      A_IMSK, A_ISTAT: mapped = 1'b1;
`endif
      default: mapped = 1'b0;
    endcase
  end

  assign pslverr = acc & (~mapped | tx_push_err | rx_pop_err);

  always_comb begin
    prdata = '0;
    if (rd) begin
      case (paddr)
        A_CTRL:  prdata = {16'h0, tx_ctrl};
        A_ADDR:  prdata = {24'h0, tx_apb_addr};
        A_CNT:   prdata = {24'h0, tx_apb_data_cnt};
        A_RXD:   prdata = rx_empty ? 32'h0 : {24'h0, rx_head};
        A_STAT:  prdata = stat_word;
`ifdef I2C_REGIF_IRQ_EN
        A_IMSK:  prdata = {28'h0, irq_mask};
        A_ISTAT: prdata = {28'h0, irq_stat};
`endif
        default: prdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_apb_regif.sv
// Directed self-checking bench for i2c_apb_regif (DEPTH=8).
module tb_i2c_apb_regif;
  localparam int DEPTH = 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr, i_ready;
  logic [7:0]  status = '0;
  logic [7:0]  tx_apb_addr, tx_apb_data_cnt;
  logic [15:0] tx_ctrl;
  logic        i_txff_empty, i_txff_rd = 1'b0;
  logic [7:0]  data_out_ff;
  logic        i_rxff_full, i_rxff_wr = 1'b0;
  logic [7:0]  data_in_ff = '0;
  logic        irq;

  int checks = 0, errors = 0;

  i2c_apb_regif #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .i_ready(i_ready), .status(status), .tx_apb_addr(tx_apb_addr),
    .tx_apb_data_cnt(tx_apb_data_cnt), .tx_ctrl(tx_ctrl), .i_txff_empty(i_txff_empty),
    .i_txff_rd(i_txff_rd), .data_out_ff(data_out_ff), .i_rxff_full(i_rxff_full),
    .i_rxff_wr(i_rxff_wr), .data_in_ff(data_in_ff), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d, output logic err);
    @(negedge clk); psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(negedge clk); penable = 1; #1 err = pslverr;
    @(posedge clk); #1 psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_rd(input logic [7:0] a, output logic [31:0] d, output logic err);
    @(negedge clk); psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(negedge clk); penable = 1; #1 d = prdata; err = pslverr;
    @(posedge clk); #1 psel = 0; penable = 0;
  endtask

  task automatic core_txpop();
    @(negedge clk); i_txff_rd = 1;
    @(posedge clk); #1 i_txff_rd = 0;
  endtask

  task automatic core_rxpush(input logic [7:0] b);
    @(negedge clk); i_rxff_wr = 1; data_in_ff = b;
    @(posedge clk); #1 i_rxff_wr = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e;
    rst = 1; repeat (3) @(posedge clk); #1 rst = 0;
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL rst_iready got %b exp 0", i_ready); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
    checks++; if ({prdata, pslverr} !== 33'h0) begin errors++; $display("FAIL rst_bus got %h/%b exp 0/0", prdata, pslverr); end
    checks++; if ({i_txff_empty, i_rxff_full, tx_ctrl} !== {2'b10, 16'h0}) begin errors++; $display("FAIL rst_flags got %b%b %h exp 10 0000", i_txff_empty, i_rxff_full, tx_ctrl); end
    apb_rd(8'h14, d, e);
    checks++; if ({d, e} !== {32'h0000_0500, 1'b0}) begin errors++; $display("FAIL rst_status got %h/%b exp 00000500/0", d, e); end
    apb_rd(8'h00, d, e);
    checks++; if ({d, e} !== {32'h0, 1'b0}) begin errors++; $display("FAIL rst_ctrl got %h/%b exp 0/0", d, e); end
  endtask

  task automatic test_regs();
    logic [31:0] d; logic e;
    apb_wr(8'h00, 32'h0000_2064, e);
    apb_wr(8'h04, 32'h0000_00A0, e);
    apb_wr(8'h08, 32'h0000_0003, e);
    checks++; if ({tx_ctrl, tx_apb_addr, tx_apb_data_cnt} !== 32'h2064_A003) begin errors++; $display("FAIL regs_out got %h %h %h exp 2064 a0 03", tx_ctrl, tx_apb_addr, tx_apb_data_cnt); end
    apb_rd(8'h04, d, e);
    checks++; if (d !== 32'h0000_00A0) begin errors++; $display("FAIL regs_addr_rd got %h exp 000000a0", d); end
    apb_wr(8'h00, 32'hABCD_1234, e);
    apb_rd(8'h00, d, e);
    checks++; if (d !== 32'h0000_1234) begin errors++; $display("FAIL regs_ctrl_trunc got %h exp 00001234", d); end
  endtask

  task automatic test_tx();
    logic [31:0] d; logic e;
    apb_wr(8'h0C, 32'h11, e);
    apb_wr(8'h0C, 32'h22, e);
    apb_rd(8'h14, d, e);
    checks++; if (d !== 32'h0002_0400) begin errors++; $display("FAIL tx_lvl2 got %h exp 00020400", d); end
    checks++; if (data_out_ff !== 8'h11) begin errors++; $display("FAIL tx_head0 got %h exp 11", data_out_ff); end
    core_txpop();
    checks++; if (data_out_ff !== 8'h22) begin errors++; $display("FAIL tx_head1 got %h exp 22", data_out_ff); end
    core_txpop();
    core_txpop();  // pop on empty is ignored
    checks++; if (i_txff_empty !== 1'b1) begin errors++; $display("FAIL tx_empty got %b exp 1", i_txff_empty); end
    apb_rd(8'h14, d, e);
    checks++; if (d !== 32'h0000_0500) begin errors++; $display("FAIL tx_lvl0 got %h exp 00000500", d); end
  endtask

  task automatic test_tx_ovf();
    logic [31:0] d; logic e;
    for (int i = 0; i <= DEPTH; i++) begin
      apb_wr(8'h0C, 32'h80 + i, e);
      checks++;
      if (e !== (i == DEPTH)) begin errors++; $display("FAIL tx_ovf_err%0d got %b exp %b", i, e, (i == DEPTH)); end
    end
    apb_rd(8'h14, d, e);
    checks++; if (d !== 32'h0008_1600) begin errors++; $display("FAIL tx_ovf_status got %h exp 00081600", d); end
    checks++; if (data_out_ff !== 8'h80) begin errors++; $display("FAIL tx_ovf_head got %h exp 80", data_out_ff); end
    apb_wr(8'h14, 32'h0000_1000, e);
    apb_rd(8'h14, d, e);
    checks++; if (d !== 32'h0008_0600) begin errors++; $display("FAIL tx_ovf_clr got %h exp 00080600", d); end
    // push into full while core pops: push still rejected
    @(negedge clk); psel = 1; penable = 0; pwrite = 1; paddr = 8'h0C; pwdata = 32'hEE;
    @(negedge clk); penable = 1; i_txff_rd = 1; #1 e = pslverr;
    @(posedge clk); #1 psel = 0; penable = 0; pwrite = 0; i_txff_rd = 0;
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL full_pushpop_err got %b exp 1", e); end
    apb_rd(8'h14, d, e);
    checks++; if (d !== 32'h0007_1400) begin errors++; $display("FAIL full_pushpop_status got %h exp 00071400", d); end
    apb_wr(8'h14, 32'h0000_1000, e);
    apb_wr(8'h18, 32'h2, e);
    checks++; if ({i_txff_empty, i_ready} !== 2'b10) begin errors++; $display("FAIL tx_flush got %b%b exp 10", i_txff_empty, i_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e;
    apb_wr(8'h0C, 32'h01, e);
    @(negedge clk); psel = 1; penable = 0; pwrite = 1; paddr = 8'h0C; pwdata = 32'h02;
    @(negedge clk); penable = 1; i_txff_rd = 1;
    @(posedge clk); #1 psel = 0; penable = 0; pwrite = 0; i_txff_rd = 0;
    checks++; if (data_out_ff !== 8'h02) begin errors++; $display("FAIL b2b_head got %h exp 02", data_out_ff); end
    apb_rd(8'h14, d, e);
    checks++; if (d !== 32'h0001_0400) begin errors++; $display("FAIL b2b_lvl got %h exp 00010400", d); end
    apb_wr(8'h18, 32'h2, e);
  endtask

  task automatic test_rx();
    logic [31:0] d; logic e;
    core_rxpush(8'h5A);
    apb_rd(8'h10, d, e);
    checks++; if ({d, e} !== {32'h5A, 1'b0}) begin errors++; $display("FAIL rx_pop got %h/%b exp 5a/0", d, e); end
    apb_rd(8'h10, d, e);
    checks++; if ({d, e} !== {32'h0, 1'b1}) begin errors++; $display("FAIL rx_udf_rd got %h/%b exp 0/1", d, e); end
    apb_rd(8'h14, d, e);
    checks++; if (d !== 32'h0000_2500) begin errors++; $display("FAIL rx_udf_status got %h exp 00002500", d); end
    apb_wr(8'h14, 32'h0000_2000, e);
    for (int i = 0; i <= DEPTH; i++) core_rxpush(8'h30 + 8'(i));
    checks++; if (i_rxff_full !== 1'b1) begin errors++; $display("FAIL rx_full got %b exp 1", i_rxff_full); end
    apb_rd(8'h14, d, e);
    checks++; if (d !== 32'h0800_4900) begin errors++; $display("FAIL rx_ovf_status got %h exp 08004900", d); end
    apb_rd(8'h10, d, e);
    checks++; if (d !== 32'h30) begin errors++; $display("FAIL rx_full_head got %h exp 30", d); end
    apb_wr(8'h18, 32'h4, e);
    apb_rd(8'h14, d, e);
    checks++; if (d !== 32'h0000_4500) begin errors++; $display("FAIL rx_flush got %h exp 00004500", d); end
    apb_wr(8'h14, 32'h0000_4000, e);
  endtask

  task automatic test_cmd();
    logic e;
    apb_wr(8'h18, 32'h1, e);
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL cmd_pulse got %b exp 1", i_ready); end
    @(posedge clk); #1;
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL cmd_pulse_end got %b exp 0", i_ready); end
    apb_wr(8'h0C, 32'h77, e);
    apb_wr(8'h18, 32'h3, e);
    checks++; if ({i_ready, i_txff_empty} !== 2'b11) begin errors++; $display("FAIL cmd_go_flush got %b%b exp 11", i_ready, i_txff_empty); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic e;
    apb_rd(8'h24, d, e);
    checks++; if ({d, e} !== {32'h0, 1'b1}) begin errors++; $display("FAIL unmap_24 got %h/%b exp 0/1", d, e); end
    apb_rd(8'h02, d, e);
    checks++; if ({d, e} !== {32'h0, 1'b1}) begin errors++; $display("FAIL unmap_02 got %h/%b exp 0/1", d, e); end
    apb_rd(8'h0C, d, e);
    checks++; if ({d, e} !== {32'h0, 1'b0}) begin errors++; $display("FAIL txdata_rd got %h/%b exp 0/0", d, e); end
    status = 8'h0A;
    apb_rd(8'h14, d, e);
    checks++; if (d !== 32'h0000_050A) begin errors++; $display("FAIL core_status got %h exp 0000050a", d); end
    status = 8'h00;
`ifndef I2C_REGIF_IRQ_EN
    apb_wr(8'h1C, 32'h1, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL irq_unmapped got %b exp 1", e); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied got %b exp 0", irq); end
`endif
  endtask

`ifdef I2C_REGIF_IRQ_EN
  task automatic test_irq();
    logic [31:0] d; logic e;
    apb_wr(8'h1C, 32'h1, e);
    repeat (2) @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b exp 0", irq); end
    @(negedge clk); status = 8'h08;
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency got %b exp 0", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b exp 1", irq); end
    apb_wr(8'h20, 32'h1, e);
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr got %b exp 0", irq); end
    apb_rd(8'h20, d, e);
    checks++; if (d[0] !== 1'b0) begin errors++; $display("FAIL irq_stat0 got %b exp 0", d[0]); end
    status = 8'h00;
  endtask
`endif

  task automatic test_reset_mid();
    logic e;
    apb_wr(8'h00, 32'h3064, e);
    apb_wr(8'h0C, 32'h55, e);
    core_rxpush(8'h66);
    @(negedge clk); rst = 1;
    @(posedge clk); #1 rst = 0;
    checks++; if ({tx_ctrl, i_txff_empty, i_rxff_full} !== {16'h0, 2'b10}) begin errors++; $display("FAIL rst_mid got %h %b%b exp 0000 10", tx_ctrl, i_txff_empty, i_rxff_full); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_tx();
    test_tx_ovf();
    test_back_to_back();
    test_rx();
    test_cmd();
    test_unmapped();
`ifdef I2C_REGIF_IRQ_EN
    test_irq();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
